// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared slice width, FSM state type and slice-count helper for the CLA subtractor
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } cla_sub_state_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla_subtractor_seq_cla4_slice.sv
// rtl/cla_subtractor_seq_cla4_slice.sv - combinational 4-bit carry-lookahead slice (cla4_slice)
module cla4_slice (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       cin,
  output logic [3:0] s4,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1, c2, c3;

  assign g = a4 & b4;
  assign p = a4 ^ b4;

  // Carries are expanded directly from generate/propagate rather than rippled.
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s4 = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_subtractor_seq.sv
// rtl/cla_subtractor_seq.sv - multi-cycle a - b - bin using one time-multiplexed CLA slice
// Optional macro CLA_SUB_SAT_EN: clamp diff to zero on underflow (unsigned saturation).
module cla_subtractor_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  cla_sub_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] nb_q;
  logic             carry;
  logic [3:0]       slice_s;
  logic             slice_cout;
  logic             last_slice;

  cla4_slice u_slice (
    .a4   (a_q[SLICE_W*cnt +: SLICE_W]),
    .b4   (nb_q[SLICE_W*cnt +: SLICE_W]),
    .cin  (carry),
    .s4   (slice_s),
    .cout (slice_cout)
  );

  assign last_slice = (cnt == CNT_W'(NSLICE - 1));
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      nb_q  <= '0;
      carry <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction as a + ~b + ~bin; the final carry is the inverted borrow.
            a_q   <= a;
            nb_q  <= ~b;
            carry <= ~bin;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          diff[SLICE_W*cnt +: SLICE_W] <= slice_s;
          carry <= slice_cout;
          cnt   <= cnt + CNT_W'(1);
          if (last_slice) begin
            bout  <= ~slice_cout;
            state <= DONE;
`ifdef CLA_SUB_SAT_EN
            if (!slice_cout) diff <= '0;
`endif
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_subtractor_seq.sv
// tb/tb_cla_subtractor_seq.sv - randomized and directed self-checking bench for cla_subtractor_seq
module tb_cla_subtractor_seq;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int checks = 0;
  int failures = 0;

  cla_subtractor_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain signed integer arithmetic on the operands.
  task automatic ref_sub(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb, input logic rbin,
                         output logic [WIDTH-1:0] rdiff, output logic rbout);
    int full;
    full  = int'(ra) - int'(rb) - int'(rbin);
    rbout = (full < 0);
    rdiff = WIDTH'(full + (1 << WIDTH));
`ifdef CLA_SUB_SAT_EN
    if (rbout) rdiff = '0;
`endif
  endtask

  task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic obin,
                       input int hold);
    logic [WIDTH-1:0] ediff;
    logic             ebout;
    int               lat;
    ref_sub(oa, ob, obin, ediff, ebout);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = oa; b = ob; bin = obin; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
    lat = 0;
    check("in_ready_busy", 32'(in_ready), 32'd0);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("diff", 32'(diff), 32'(ediff));
    check("bout", 32'(bout), 32'(ebout));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_diff", 32'(diff), 32'(ediff));
      check("hold_bout", 32'(bout), 32'(ebout));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'h1234, 16'h0234, 1'b0, 0);
    do_op(16'h0000, 16'h0001, 1'b0, 0);
    do_op(16'hA5A5, 16'hA5A5, 1'b1, 0);
    do_op(16'hA5A5, 16'hA5A5, 1'b0, 0);
    do_op(16'h1000, 16'h0001, 1'b0, 0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 0);
    do_op(16'h0000, 16'hFFFF, 1'b1, 0);
    do_op(16'h8000, 16'h7FFF, 1'b0, 5);

    // Reset while the second slice is being computed.
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_diff", 32'(diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0005, 16'h0003, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
